fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the team's 16-deep, 8-bit synchronous FIFO among NREQ independent producers. Each owner holds the grant for a bounded burst. FIFO backpressure (full) is honoured, and per-requester acknowledges are returned. Sits directly in front of the FIFO write side (wr/din/full) in the same clock domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 8, data width; matches FIFO din
- BURST, 4, maximum words per grant (1..15)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-low reset (rst==0 at a rising clk edge resets)
- req  in  NREQ  requester i has a word presented; held until acked
- din_req  in  NREQ*DW  requester i data at bits [i*DW +: DW]
- ack  out  NREQ  one-hot; word of requester i accepted this cycle (combinational)
- gnt  out  NREQ  one-hot registered current owner; 0 when idle
- busy  out  1  registered; 1 while a grant is held
- fifo_full  in  1  FIFO full flag
- fifo_wr  out  1  FIFO write strobe (combinational)
- fifo_din  out  DW  FIFO write data (combinational mux of owner's data)

## Operation
- FSM states: IDLE, OWN. Registers: state, owner (index), last (index), cnt (4 bits).
- IDLE: if any req bit is set, select the first set bit scanning last+1, last+2, … modulo NREQ. Load owner, set gnt one-hot, set cnt=0, and go to OWN. No transfer happens in an IDLE cycle.
- OWN transfer condition xfer = req[owner] && !fifo_full.
  - When xfer is true: fifo_wr=1, ack[owner]=1, fifo_din=din_req[owner], and cnt increments.
  - When xfer is false: fifo_wr=0, all ack=0, and fifo_din is still driven from owner (don't-care).
- OWN release: go to IDLE, last<=owner, gnt<=0 when either
  - xfer occurs with cnt==BURST-1, or
  - req[owner]==0.
- fifo_full in OWN: grant is retained, cnt is held, and there is no timeout. The owner stalls until full clears or it drops req.
- Requesters other than owner never see ack. Their req and data are ignored until granted.
- Reset values: state=IDLE, gnt=0, busy=0, cnt=0, owner=0, last=NREQ-1 (requester 0 wins the first arbitration), fifo_wr=0, ack=0.
- Reset mid-burst: all of the above takes effect at the reset edge. A word offered in that cycle is not written.
- Changes to req bits of non-owners while in OWN do not affect the current grant.

## Timing
- Arbitration latency: req seen in IDLE at edge N gives gnt at N+1. The first ack/fifo_wr can occur in cycle N+1.
- Each xfer cycle writes one word. The FIFO captures din on the same edge.
- One IDLE bubble follows every release. Peak throughput is BURST words per BURST+1 cycles.
- ack and fifo_wr are combinational from registered state, req[owner] and fifo_full. They have no registered lag, so a write is never issued while full.
- busy == (state==OWN), and gnt is nonzero exactly when busy==1.

## Configuration
- FIFO_ARB_PRIO_EN defined: in IDLE, if req[0]==1, requester 0 is granted regardless of last. Otherwise normal round-robin applies. last updates on every release as usual. BURST limits still apply to requester 0, so it cannot starve others within a grant, but it wins every arbitration it participates in.
- FIFO_ARB_PRIO_EN undefined: pure round-robin; all requesters are equal.

## Test plan
- Reset, then only req[2]=1 for 6 words (data 0x10..0x15), BURST=4, full=0 -> gnt=0b0100 one cycle after req; fifo_wr on 4 consecutive cycles writing 0x10..0x13; 1 idle cycle; then 2 writes 0x14, 0x15; gnt=0 afterwards.
- req=0b1111 held continuously, full=0 -> grant order 0,1,2,3,0. Each grant has exactly 4 acks followed by 1 bubble, and there are never two ack bits set at once.
- Owner 1 mid-burst after 2 words, fifo_full=1 for 3 cycles -> fifo_wr=0 and ack=0 for those 3 cycles with gnt unchanged; then exactly 2 more words before release.
- Owner 3 drops req after 1 word while req[0]=1 -> release with last=3; requester 0 is granted next, total 1 word written by requester 3.
- rst=0 asserted mid-burst with owner 2 -> next cycle gnt=0, busy=0, fifo_wr=0. With req=0b0110 after release, requester 1 is granted first (last reset to NREQ-1).
- With FIFO_ARB_PRIO_EN, req=0b1011 held -> grant sequence 0,0,0… (requester 0 re-wins each IDLE). Without the macro, the sequence is 0,1,3,0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ producers, with bounded bursts.
// Optional macro FIFO_ARB_PRIO_EN: requester 0 wins every arbitration it takes part in.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned BURST = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din_req,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    gnt,
  output logic               busy,
  input  logic               fifo_full,
  output logic               fifo_wr,
  output logic [DW-1:0]      fifo_din
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t            r_state;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     r_last;
  logic [CW-1:0]     r_cnt;
  logic [NREQ-1:0]   r_gnt;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [IW-1:0]     w_owner_nxt;
  logic [IW-1:0]     w_last_nxt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic              w_busy_nxt;

  logic              w_found;
  logic [IW-1:0]     w_pick;
  logic              w_xfer;
  logic              w_owner_req;
  logic [DW-1:0]     w_din_arr [NREQ];

  // Unpack requester data lanes so the owner mux is a plain array index.
  for (genvar g = 0; g < int'(NREQ); g++) begin : g_lane
    assign w_din_arr[g] = din_req[g*DW +: DW];
  end

  assign w_owner_req = req[r_owner];

  // Rotating search starting just after the last released owner.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      if (!w_found && req[IW'((int'(r_last) + i) % int'(NREQ))]) begin
        w_found = 1'b1;
        w_pick  = IW'((int'(r_last) + i) % int'(NREQ));
      end
    end
`ifdef FIFO_ARB_PRIO_EN
    if (req[0]) begin
      w_pick = '0;
    end
`endif
  end

  // Next-state and combinational write-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = r_gnt;
    w_xfer      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OWN;
          w_owner_nxt = w_pick;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = NREQ'(1) << w_pick;
        end
      end
      S_OWN: begin
        w_xfer = w_owner_req && !fifo_full;
        if (w_xfer) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if ((w_xfer && (r_cnt == CNT_LAST)) || !w_owner_req) begin
          w_state_nxt = S_IDLE;
          w_last_nxt  = r_owner;
          w_cnt_nxt   = '0;
          w_gnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase

    w_busy_nxt = (w_state_nxt == S_OWN);
  end

  // A word offered while reset is asserted must not reach the FIFO.
  assign fifo_wr  = w_xfer && rst;
  assign ack      = fifo_wr ? (NREQ'(1) << r_owner) : '0;
  assign fifo_din = w_din_arr[r_owner];
  assign gnt      = r_gnt;
  assign busy     = r_busy;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= LAST_RST;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NREQ=4, DW=8, BURST=4); honours FIFO_ARB_PRIO_EN.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] din_req;
  logic [3:0]  ack;
  logic [3:0]  gnt;
  logic        busy;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_din;

  int total;
  int bad;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din_req   (din_req),
    .ack       (ack),
    .gnt       (gnt),
    .busy      (busy),
    .fifo_full (fifo_full),
    .fifo_wr   (fifo_wr),
    .fifo_din  (fifo_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs (inputs already applied), then advance past the next edge.
  task automatic step(input logic [3:0] eg, input logic eb, input logic ew,
                      input logic [3:0] ea, input logic [7:0] ed);
    #1;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("busy", 32'(busy), 32'(eb));
    chk("fifo_wr", 32'(fifo_wr), 32'(ew));
    chk("ack", 32'(ack), 32'(ea));
    if (ew) chk("fifo_din", 32'(fifo_din), 32'(ed));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req       = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    #1;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    rst = 1'b1;
  endtask

  initial begin
    int order2 [5];
    int order6 [4];
`ifdef FIFO_ARB_PRIO_EN
    order2 = '{0, 0, 0, 0, 0};
    order6 = '{0, 0, 0, 0};
`else
    order2 = '{0, 1, 2, 3, 0};
    order6 = '{0, 1, 3, 0};
`endif
    total   = 0;
    bad     = 0;
    din_req = '0;
    do_reset();

    // Lone requester 2, six words across two grants.
    req = 4'b0100; din_req[23:16] = 8'h10;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h10);
    din_req[23:16] = 8'h11;
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h11);
    din_req[23:16] = 8'h12;
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h12);
    din_req[23:16] = 8'h13;
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h13);
    din_req[23:16] = 8'h14;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h14);
    din_req[23:16] = 8'h15;
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h15);
    req = 4'b0000;
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 8'h00);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    // All four requesting continuously.
    do_reset();
    din_req = 32'hA3A2A1A0;
    req     = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < 4; k++) begin
        step(4'(1 << order2[g]), 1'b1, 1'b1, 4'(1 << order2[g]), 8'(8'hA0 + order2[g]));
      end
    end
    req = 4'b0000;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    // Owner 1 stalled by a full FIFO mid-burst.
    do_reset();
    din_req[15:8] = 8'h31;
    req = 4'b0010;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0010, 1'b1, 1'b1, 4'b0010, 8'h31);
    step(4'b0010, 1'b1, 1'b1, 4'b0010, 8'h31);
    fifo_full = 1'b1;
    for (int k = 0; k < 3; k++) step(4'b0010, 1'b1, 1'b0, 4'b0000, 8'h00);
    fifo_full = 1'b0;
    step(4'b0010, 1'b1, 1'b1, 4'b0010, 8'h31);
    step(4'b0010, 1'b1, 1'b1, 4'b0010, 8'h31);
    req = 4'b0000;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    // Owner 3 drops req after one word; requester 0 is next.
    do_reset();
    din_req[31:24] = 8'h44; din_req[7:0] = 8'h40;
    req = 4'b1000;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    req = 4'b1001;
    step(4'b1000, 1'b1, 1'b1, 4'b1000, 8'h44);
    req = 4'b0001;
    step(4'b1000, 1'b1, 1'b0, 4'b0000, 8'h00);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0001, 1'b1, 1'b1, 4'b0001, 8'h40);
    req = 4'b0000;
    step(4'b0001, 1'b1, 1'b0, 4'b0000, 8'h00);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    // Reset mid-burst with owner 2; last returns to 3.
    do_reset();
    din_req[23:16] = 8'h55; din_req[15:8] = 8'h66;
    req = 4'b0100;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h55);
    step(4'b0100, 1'b1, 1'b1, 4'b0100, 8'h55);
    rst = 1'b0;
    step(4'b0100, 1'b1, 1'b0, 4'b0000, 8'h00);
    rst = 1'b1;
    req = 4'b0110;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
    step(4'b0010, 1'b1, 1'b1, 4'b0010, 8'h66);
    req = 4'b0000;
    step(4'b0010, 1'b1, 1'b0, 4'b0000, 8'h00);
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    // req=1011 held: round-robin, or requester 0 always with priority.
    do_reset();
    din_req = 32'hA3A2A1A0;
    req     = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < 4; k++) begin
        step(4'(1 << order6[g]), 1'b1, 1'b1, 4'(1 << order6[g]), 8'(8'hA0 + order6[g]));
      end
    end
    req = 4'b0000;
    step(4'b0000, 1'b0, 1'b0, 4'b0000, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
